// File: rtl/divisor_secuencial.sv
// divisor_secuencial: sequential 8-bit unsigned restoring divider.
// One quotient bit is produced per clock. A divide takes 8 cycles, and a
// divide by zero takes 1 cycle.
// Input handshake is start_i/ready_o. Output handshake is valid_o/ack_i.
// Optional feature macro: DIVSEQ_DIVZERO_FLAG_EN adds the div_zero_o port.
module divisor_secuencial (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  output logic       ready_o,
  output logic       valid_o,
  input  logic       ack_i,
  output logic [7:0] quotient_o,
  output logic [7:0] remainder_o
`ifdef DIVSEQ_DIVZERO_FLAG_EN
  ,
  output logic       div_zero_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One restoring step.
  // Bring the next dividend bit into the partial remainder and try to
  // subtract the divisor. Bit 8 of the 9-bit difference is the borrow.
  // The partial remainder is always below the divisor, so a non-negative
  // difference always fits in 8 bits.
  // The returned value is {quotient_bit, next_partial[8:0]}.
  function automatic logic [9:0] f_restore_step(
    input logic [8:0] partial,
    input logic       dividend_msb,
    input logic [7:0] divisor
  );
    logic [8:0] shifted;
    logic [8:0] trial;
    shifted = {partial[7:0], dividend_msb};
    trial   = shifted - {1'b0, divisor};
    if (trial[8] == 1'b0) begin
      f_restore_step = {1'b1, trial};
    end else begin
      f_restore_step = {1'b0, shifted};
    end
  endfunction

  state_t      r_state;
  logic [7:0]  r_dividend;   // dividend bits shift out, quotient bits shift in
  logic [7:0]  r_divisor;
  logic [8:0]  r_partial;
  logic [2:0]  r_count;
  logic        r_ready;
  logic        r_valid;
  logic [7:0]  r_quotient;
  logic [7:0]  r_remainder;
`ifdef DIVSEQ_DIVZERO_FLAG_EN
  logic        r_div_zero;
`endif

  logic [9:0]  w_step;
  logic        w_qbit;
  logic [8:0]  w_next_partial;
  logic        w_last;
  logic        w_divisor_zero;

  assign w_step         = f_restore_step(r_partial, r_dividend[7], r_divisor);
  assign w_qbit         = w_step[9];
  assign w_next_partial = w_step[8:0];
  assign w_last         = (r_count == 3'd7);
  assign w_divisor_zero = (r_divisor == 8'd0);

  // Control FSM and datapath with registered handshake and result outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_dividend  <= 8'd0;
      r_divisor   <= 8'd0;
      r_partial   <= 9'd0;
      r_count     <= 3'd0;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
      r_quotient  <= 8'd0;
      r_remainder <= 8'd0;
`ifdef DIVSEQ_DIVZERO_FLAG_EN
      r_div_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // ready_o is high in IDLE, so start_i alone is the accept condition.
          if (start_i) begin
            r_dividend <= data0_i;
            r_divisor  <= data1_i;
            r_partial  <= 9'd0;
            r_count    <= 3'd0;
            r_ready    <= 1'b0;
            if (data1_i == 8'd0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_BUSY: begin
          r_partial  <= w_next_partial;
          r_dividend <= {r_dividend[6:0], w_qbit};
          r_count    <= r_count + 3'd1;
          // The counter wraps from 7 to 0 on the 8th step.
          // The last quotient bit and the final remainder are taken straight
          // from this step, so the result registers load on the same edge.
          if (w_last) begin
            r_state     <= ST_DONE;
            r_valid     <= 1'b1;
            r_quotient  <= {r_dividend[6:0], w_qbit};
            r_remainder <= w_next_partial[7:0];
`ifdef DIVSEQ_DIVZERO_FLAG_EN
            r_div_zero  <= 1'b0;
`endif
          end else begin
            r_state <= ST_BUSY;
          end
        end

        ST_DONE: begin
          // A divide by zero enters DONE with valid_o low.
          // Its fixed result is published one edge later, with no iterations.
          // ack_i has no effect until valid_o is high.
          if (!r_valid) begin
            r_valid     <= 1'b1;
            r_quotient  <= 8'hFF;
            r_remainder <= r_dividend;
`ifdef DIVSEQ_DIVZERO_FLAG_EN
            r_div_zero  <= w_divisor_zero;
`endif
          end else if (ack_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign valid_o     = r_valid;
  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;
`ifdef DIVSEQ_DIVZERO_FLAG_EN
  assign div_zero_o  = r_div_zero;
`endif

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: table-driven bench for divisor_secuencial.
// A scoreboard queue carries each expected result from drive time to the cycle where valid_o rises.
module tb_divisor_secuencial;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] data0_i;
  logic [7:0] data1_i;
  logic       ready_o;
  logic       valid_o;
  logic       ack_i;
  logic [7:0] quotient_o;
  logic [7:0] remainder_o;
`ifdef DIVSEQ_DIVZERO_FLAG_EN
  logic       div_zero_o;
`endif

  divisor_secuencial dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .data0_i     (data0_i),
    .data1_i     (data1_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .ack_i       (ack_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
`ifdef DIVSEQ_DIVZERO_FLAG_EN
    ,
    .div_zero_o  (div_zero_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         hold;   // cycles to hold ack_i low after valid_o; 0 = ack held high
    int         lat;    // expected accept-to-valid latency in cycles
    bit         junk;   // pulse start_i with new operands while BUSY/DONE
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } res_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];
  res_t sb [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready_o"}, ready_o, 1);
    chk({tag, " valid_o"}, valid_o, 0);
    chk({tag, " quotient_o"}, quotient_o, 0);
    chk({tag, " remainder_o"}, remainder_o, 0);
`ifdef DIVSEQ_DIVZERO_FLAG_EN
    chk({tag, " div_zero_o"}, div_zero_o, 0);
`endif
  endtask

  // All driving and sampling happens on negedges, away from the active edge.
  task automatic do_op(input vec_t v);
    int   n;
    int   lat;
    res_t exp_res;
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("ready before accept", ready_o, 1);
    start_i = 1'b1;
    data0_i = v.a;
    data1_i = v.b;
    ack_i   = (v.hold == 0);
    sb.push_back('{q: v.q, r: v.r, dz: v.dz});
    @(negedge clk_i);                       // accept edge N has passed
    chk("ready low after accept", ready_o, 0);
    start_i = v.junk;
    data0_i = 8'($urandom);
    data1_i = 8'($urandom);
    lat = 0;
    while (valid_o !== 1'b1 && lat < 20) begin
      @(negedge clk_i);
      lat++;
      data0_i = 8'($urandom);
      data1_i = 8'($urandom);
    end
    chk("latency", lat, v.lat);
    chk("ready low while valid", ready_o, 0);
    if (sb.size() == 0) begin
      chk("scoreboard nonempty", 0, 1);
    end else begin
      exp_res = sb.pop_front();
      chk("quotient", quotient_o, exp_res.q);
      chk("remainder", remainder_o, exp_res.r);
`ifdef DIVSEQ_DIVZERO_FLAG_EN
      chk("div_zero", div_zero_o, exp_res.dz);
`endif
    end
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk_i);
      data0_i = 8'($urandom);
      data1_i = 8'($urandom);
      chk("valid held", valid_o, 1);
      chk("quotient held", quotient_o, v.q);
      chk("remainder held", remainder_o, v.r);
    end
    ack_i = 1'b1;
    @(negedge clk_i);                       // ack edge has passed
    start_i = 1'b0;
    ack_i   = 1'b0;
    chk("valid dropped after ack", valid_o, 0);
    chk("ready back after ack", ready_o, 1);
    chk("quotient kept in idle", quotient_o, v.q);
    chk("remainder kept in idle", remainder_o, v.r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          a       b       q        r       dz    hold lat junk
    tbl[0] = '{8'd200, 8'd7,   8'd28,   8'd4,   1'b0, 0, 8, 1'b0};
    tbl[1] = '{8'd255, 8'd1,   8'd255,  8'd0,   1'b0, 0, 8, 1'b0};
    tbl[2] = '{8'd5,   8'd9,   8'd0,    8'd5,   1'b0, 0, 8, 1'b0};
    tbl[3] = '{8'd255, 8'd255, 8'd1,    8'd0,   1'b0, 0, 8, 1'b0};
    tbl[4] = '{8'd123, 8'd0,   8'hFF,   8'd123, 1'b1, 0, 1, 1'b0};
    tbl[5] = '{8'd100, 8'd3,   8'd33,   8'd1,   1'b0, 5, 8, 1'b0};
    tbl[6] = '{8'd250, 8'd16,  8'd15,   8'd10,  1'b0, 3, 8, 1'b1};
    tbl[7] = '{8'd17,  8'd0,   8'hFF,   8'd17,  1'b1, 2, 1, 1'b1};
    tbl[8] = '{8'd0,   8'd5,   8'd0,    8'd0,   1'b0, 0, 8, 1'b0};
    tbl[9] = '{8'd128, 8'd2,   8'd64,   8'd0,   1'b0, 1, 8, 1'b0};
    for (int i = 10; i < NVEC; i++) begin
      v.a = 8'($urandom);
      v.b = 8'($urandom_range(1, 255));
      v.q = v.a / v.b;
      v.r = v.a % v.b;
      v.dz = 1'b0;
      v.hold = i % 3;
      v.lat = 8;
      v.junk = (i % 2) == 0;
      tbl[i] = v;
    end

    rst_ni  = 1'b0;
    start_i = 1'b0;
    ack_i   = 1'b0;
    data0_i = 8'd0;
    data1_i = 8'd0;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle stays idle without start", ready_o, 1);

    for (int i = 0; i < NVEC; i++) begin
      do_op(tbl[i]);
    end

    // Reset abort: accept 100/3, then pull rst_ni low after the 4th iteration
    start_i = 1'b1;
    data0_i = 8'd100;
    data1_i = 8'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("abort: busy after accept", ready_o, 0);
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("abort: no stale valid", valid_o, 0);
    end
    v = '{8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 0, 8, 1'b0};
    do_op(v);

    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
